// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   ps2_tx_state_t   - transmitter FSM state encoding
//   PS2_CMD_*        - host-to-device command bytes
//   PS2_RSP_*        - device response bytes, used by the receiver side
//   ps2_odd_parity() - parity bit that makes data+parity carry an odd number of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pin.
//   i_clk   - block clock
//   i_rst_n - asynchronous active-low reset
//   i_pin   - raw asynchronous pin level
//   o_level - filtered level (idle high after reset)
//   o_fall  - one-cycle strobe after o_level goes 1 -> 0
// The pin goes through a 2-FF synchronizer; the filtered level only changes
// once 4 consecutive synchronized samples agree on the new value.
module ps2_line_filter (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic [2:0] r_hist;
  logic       r_level;
  logic       r_level_q;
  logic       r_fall;
  logic       w_sample;
  logic       w_stable;

  assign w_sample = r_sync[1];
  // Current sample plus the three before it all equal and different from the level.
  assign w_stable = (r_hist == {3{w_sample}}) && (w_sample != r_level);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= 2'b11;
      r_hist    <= 3'b111;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_pin};
      r_hist    <= {r_hist[1:0], w_sample};
      if (w_stable) r_level <= w_sample;
      r_level_q <= r_level;
      r_fall    <= r_level_q & ~r_level;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter.
//   CLK, nRESET            - block clock, asynchronous active-low reset
//   tx_data, tx_valid      - byte and request; accepted on tx_valid && tx_ready
//   tx_ready               - high only in IDLE
//   busy                   - high whenever not IDLE
//   tx_done / tx_error     - one-cycle completion / failure pulses
//   PS2_CLK_IN, PS2_DAT_IN - raw open-collector pin levels
//   PS2_CLK_OE, PS2_DAT_OE - 1 pulls the corresponding line low
// Handshake: a byte is taken at the rising CLK edge where tx_valid and
// tx_ready are both high; tx_valid outside IDLE is ignored.
// Optional macro PS2_TX_RETRY_EN: a failed frame is resent up to two more
// times before tx_error is raised.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 14000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);

  localparam longint INH_L   = (longint'(CLK_HZ) * longint'(INHIBIT_US)) / 64'd1000000;
  localparam longint TO_L    = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / 64'd1000000;
  localparam int     INH_CNT = int'(INH_L);
  localparam int     TO_CNT  = int'(TO_L);
  localparam int     MAX_CNT = (TO_CNT > INH_CNT) ? TO_CNT : INH_CNT;
  localparam int     CNT_W   = $clog2(MAX_CNT);

  ps2_tx_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic             r_par;
  logic [3:0]       r_idx;
  logic [15:0]      w_frame;
  logic             w_clk_level, w_clk_fall;
  logic             w_dat_level, w_dat_fall_unused;
  logic             w_accept, w_inh_last, w_timeout, w_tmo_state;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       r_retry;
`endif

  ps2_line_filter u_clk_filt (
    .i_clk(CLK), .i_rst_n(nRESET), .i_pin(PS2_CLK_IN),
    .o_level(w_clk_level), .o_fall(w_clk_fall)
  );

  ps2_line_filter u_dat_filt (
    .i_clk(CLK), .i_rst_n(nRESET), .i_pin(PS2_DAT_IN),
    .o_level(w_dat_level), .o_fall(w_dat_fall_unused)
  );

  // Bits 0-7 data, 8 parity, 9 stop; upper bits padded with 1 (line released).
  assign w_frame    = {6'h3F, 1'b1, r_par, r_data};
  assign w_accept   = (r_state == ST_IDLE) && tx_valid;
  assign w_inh_last = (r_cnt == CNT_W'(INH_CNT - 1));
  assign w_timeout  = (r_cnt == CNT_W'(TO_CNT - 1));
  // States whose counter is restarted by device clock edges.
  assign w_tmo_state = (r_state == ST_REQ) || (r_state == ST_DATA) ||
                       (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

  always_comb begin
    w_next     = r_state;
    tx_ready   = 1'b0;
    busy       = 1'b1;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    PS2_CLK_OE = 1'b0;
    PS2_DAT_OE = 1'b0;
    case (r_state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) w_next = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        // Device clock edges are ignored here; holding the clock low wins.
        PS2_CLK_OE = 1'b1;
        if (w_inh_last) begin
          PS2_DAT_OE = 1'b1;
          w_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        PS2_DAT_OE = 1'b1;
        if (w_clk_fall)     w_next = ST_DATA;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_DATA: begin
        PS2_DAT_OE = ~w_frame[r_idx];
        if (w_clk_fall) begin
          if (r_idx == 4'd9) w_next = ST_ACK;
        end else if (w_timeout) begin
          w_next = ST_ERROR;
        end
      end
      ST_ACK: begin
        if (w_clk_fall)     w_next = w_dat_level ? ST_ERROR : ST_WAIT_IDLE;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_WAIT_IDLE: begin
        if (w_clk_level && w_dat_level) begin
          tx_done = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_timeout) begin
          w_next = ST_ERROR;
        end
      end
      ST_ERROR: begin
`ifdef PS2_TX_RETRY_EN
        if (r_retry != 2'd2) begin
          w_next = ST_INHIBIT;
        end else begin
          tx_error = 1'b1;
          w_next   = ST_IDLE;
        end
`else
        tx_error = 1'b1;
        w_next   = ST_IDLE;
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) || (w_next != r_state) || (w_tmo_state && w_clk_fall))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_data <= tx_data;
        r_par  <= ps2_odd_parity(tx_data);
      end
      if ((r_state == ST_REQ) && w_clk_fall)
        r_idx <= '0;
      else if ((r_state == ST_DATA) && w_clk_fall && (r_idx != 4'd9))
        r_idx <= r_idx + 1'b1;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)
      r_retry <= '0;
    else if (w_accept)
      r_retry <= '0;
    else if ((r_state == ST_ERROR) && (w_next == ST_INHIBIT))
      r_retry <= r_retry + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural
// PS/2 keyboard model on an open-collector bus. Scaled to a 1 MHz clock so
// the inhibit is 100 cycles and the timeout 15000 cycles.
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 1000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 15000;
  localparam int N_INH      = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int N_TO       = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int HALF       = 40;  // 12.5 kHz device clock at 1 MHz

  logic       CLK, nRESET;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, tx_done, tx_error;
  logic       PS2_CLK_OE, PS2_DAT_OE;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2_clk_pin, ps2_dat_pin;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, inh_cnt = 0, cur_run = 0, last_run = 0;
  logic clk_oe_q = 1'b0;

  assign ps2_clk_pin = !(PS2_CLK_OE || dev_clk_low);
  assign ps2_dat_pin = !(PS2_DAT_OE || dev_dat_low);

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)) dut (
    .CLK(CLK), .nRESET(nRESET), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .PS2_CLK_IN(ps2_clk_pin), .PS2_DAT_IN(ps2_dat_pin),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DAT_OE(PS2_DAT_OE)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bus monitor: pulse counts and length of each clock-inhibit run.
  always @(negedge CLK) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    if (PS2_CLK_OE) begin
      if (!clk_oe_q) inh_cnt++;
      cur_run++;
    end else begin
      if (clk_oe_q) last_run = cur_run;
      cur_run = 0;
    end
    clk_oe_q = PS2_CLK_OE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame bits the device must see for byte d (LSB first, odd parity, stop).
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // Driver: present a byte, check acceptance, keep junk on tx_valid briefly while busy.
  task automatic send(input logic [7:0] d);
    @(negedge CLK);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge CLK);
    #1;
    check("accept_clk_oe", PS2_CLK_OE, 1);
    check("accept_not_ready", tx_ready, 0);
    tx_data = 8'($urandom);
    repeat (3) @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 4 * N_INH; i++) begin
      @(negedge CLK);
      if (!PS2_CLK_OE && PS2_DAT_OE) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Device model: n_clk clock pulses, samples data at the end of each low
  // phase, optionally pulls data low as acknowledge before the 12th pulse.
  task automatic device(input int n_clk, input bit ack_low, input bit glitch,
                        output logic [9:0] bits, output bit got);
    bits = '0;
    wait_req(got);
    if (!got) return;
    repeat (20) @(negedge CLK);
    for (int i = 0; i < n_clk; i++) begin
      if (i == 11 && ack_low) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLK);
      if (i < 10) bits[i] = ps2_dat_pin;
      dev_clk_low = 1'b0;
      if (glitch && i == 3) begin
        repeat (15) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (2) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (HALF - 17) @(negedge CLK);
      end else begin
        repeat (HALF) @(negedge CLK);
      end
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit glitch);
    logic [9:0] bits, exp;
    bit got, ok;
    int d0, e0, i0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    exp = ref_frame(d);
    send(d);
    device(12, 1'b1, glitch, bits, got);
    check("req_seen", 32'(got), 1);
    wait_ready(ok);
    check("done_in_time", 32'(ok), 1);
    check("inhibit_len", last_run, N_INH);
    check("inhibit_count", inh_cnt - i0, 1);
    check("data_bits", bits[7:0], exp[7:0]);
    check("parity_bit", bits[8], exp[8]);
    check("stop_bit", bits[9], 1);
    check("done_pulses", done_cnt - d0, 1);
    check("error_pulses", err_cnt - e0, 0);
  endtask

  initial begin
    logic [9:0] bits;
    bit got, ok;
    int d0, e0, i0, cnt, exp_cnt;
    logic [7:0] rnd;

    nRESET = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_oe", PS2_CLK_OE, 0);
    check("rst_dat_oe", PS2_DAT_OE, 0);
    nRESET = 1'b1;
    repeat (5) @(negedge CLK);

    // Directed commands, then random bytes.
    run_frame(8'hED, 1'b0);
    run_frame(8'hF4, 1'b0);
    run_frame(8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom_range(0, 255));
      run_frame(rnd, 1'b0);
    end

    // Short clock glitch mid-frame must not advance the bit index.
    run_frame(8'($urandom_range(0, 255)), 1'b1);

    // Silent device: timeout measured from request entry.
    d0 = done_cnt; e0 = err_cnt;
`ifdef PS2_TX_RETRY_EN
    exp_cnt = 3 * N_TO + 2 * (N_INH + 1);
`else
    exp_cnt = N_TO;
`endif
    send(8'hFF);
    wait_req(got);
    check("silent_req_seen", 32'(got), 1);
    cnt = 0;
    for (int i = 0; i < exp_cnt + 200; i++) begin
      @(negedge CLK);
      cnt++;
      if (tx_error) break;
    end
    check("timeout_cycles", cnt, exp_cnt);
    check("timeout_clk_oe", PS2_CLK_OE, 0);
    check("timeout_dat_oe", PS2_DAT_OE, 0);
    @(negedge CLK);
    check("timeout_ready", tx_ready, 1);
    check("timeout_err_pulses", err_cnt - e0, 1);
    check("timeout_done_pulses", done_cnt - d0, 0);

    // NACK: device leaves data high at the acknowledge clock.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    send(8'hF4);
`ifdef PS2_TX_RETRY_EN
    for (int r = 0; r < 3; r++) device(12, 1'b0, 1'b0, bits, got);
`else
    device(12, 1'b0, 1'b0, bits, got);
`endif
    check("nack_req_seen", 32'(got), 1);
    wait_ready(ok);
    check("nack_ready", 32'(ok), 1);
    check("nack_frame", bits, ref_frame(8'hF4));
`ifdef PS2_TX_RETRY_EN
    check("nack_inhibits", inh_cnt - i0, 3);
`else
    check("nack_inhibits", inh_cnt - i0, 1);
`endif
    check("nack_err_pulses", err_cnt - e0, 1);
    check("nack_done_pulses", done_cnt - d0, 0);

    // Reset during bit 4 of 0xED (bit 4 is 0, so data is being pulled low).
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    device(5, 1'b1, 1'b0, bits, got);
    check("rstmid_req_seen", 32'(got), 1);
    check("rstmid_bits", bits[3:0], 4'hD);
    check("rstmid_pre_dat_oe", PS2_DAT_OE, 1);
    @(posedge CLK);
    #3;
    nRESET = 1'b0;
    #1;
    check("rstmid_clk_oe", PS2_CLK_OE, 0);
    check("rstmid_dat_oe", PS2_DAT_OE, 0);
    repeat (3) @(negedge CLK);
    nRESET = 1'b1;
    repeat (200) @(negedge CLK);
    check("rstmid_ready", tx_ready, 1);
    check("rstmid_err_pulses", err_cnt - e0, 0);
    check("rstmid_done_pulses", done_cnt - d0, 0);

    // A clean frame after the abort.
    run_frame(8'($urandom_range(0, 255)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
